// File: rtl/qspi_flash_responder_if.sv
// QSPI target pins plus the synchronous byte-memory read port of qspi_flash_responder.
// slave = responder side, master = flash controller / memory side.
interface qspi_flash_responder_if #(
    parameter int ADDR_W = 16
);
    logic              qspi_sck;
    logic              qspi_cs_0;
    logic [3:0]        qspi_dq_i;
    logic [3:0]        qspi_dq_o;
    logic [3:0]        qspi_dq_oe;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              busy;
    logic              cmd_err;

    modport slave (
        input  qspi_sck, qspi_cs_0, qspi_dq_i, mem_rdata,
        output qspi_dq_o, qspi_dq_oe, mem_rd, mem_addr, busy, cmd_err
    );

    modport master (
        output qspi_sck, qspi_cs_0, qspi_dq_i, mem_rdata,
        input  qspi_dq_o, qspi_dq_oe, mem_rd, mem_addr, busy, cmd_err
    );
endinterface

// File: rtl/qspi_flash_responder.sv
// QSPI flash target serving 0x03/0x0B reads (plus quad 0x6B when QSPI_RESP_QUAD_EN is defined) from a sync byte memory.
// Latency: sck edge to internal action 3 clocks; data output changes at most 4 clocks after the sck fall.
// Backpressure: none; the master's sck paces everything and the next byte is prefetched one byte ahead.
module qspi_flash_responder #(
    parameter int ADDR_W    = 16,
    parameter int DUMMY_CYC = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    qspi_flash_responder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;

    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYC - 1);
    localparam bit         HAS_DUMMY  = (DUMMY_CYC != 0);

    state_t            state, state_nxt;
    logic [1:0]        sck_s, cs_s;
    logic [3:0]        dq_s0, dq_s1;
    logic              sck_d, cs_d, cs_armed;
    logic              sck_rise, sck_fall, cs_rise, cs_fall;
    logic [ADDR_W-1:0] shreg, sh_nxt;
    logic [7:0]        cnt;
    logic              use_dummy, dummy_nxt, err_nxt;
    logic              rd_pend, pre_vld, drive, sampled, byte_end;
    logic [7:0]        pre_buf, byte_sh;
    logic [3:0]        bits_left;
    logic              mem_rd_q, busy_q, cmd_err_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              spare_unused;
`ifdef QSPI_RESP_QUAD_EN
    logic              quad, quad_nxt;
`else
    logic              quad;
    assign quad = 1'b0;
`endif

    assign sck_rise = sck_s[1] & ~sck_d;
    assign sck_fall = ~sck_s[1] & sck_d;
    assign cs_rise  = cs_s[1] & ~cs_d;
    // cs_d resets low so a cs still held low across reset never looks like a fresh fall
    assign cs_fall  = ~cs_s[1] & cs_d;
    assign sh_nxt   = {shreg[ADDR_W-2:0], dq_s1[0]};
    assign byte_end = drive && sck_fall && sampled && (bits_left == 4'd1);
    assign spare_unused = ^{dq_s1[3:1], shreg[ADDR_W-1]};

    always_comb begin
        state_nxt = state;
        dummy_nxt = use_dummy;
        err_nxt   = 1'b0;
`ifdef QSPI_RESP_QUAD_EN
        quad_nxt  = quad;
`endif
        if (cs_rise) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (cs_fall) state_nxt = CMD;
                CMD: begin
                    if (sck_rise && cnt == 8'd7) begin
                        state_nxt = ADDR;
                        dummy_nxt = 1'b0;
`ifdef QSPI_RESP_QUAD_EN
                        quad_nxt  = 1'b0;
`endif
                        case (sh_nxt[7:0])
                            8'h03: ;
                            8'h0B: dummy_nxt = HAS_DUMMY;
`ifdef QSPI_RESP_QUAD_EN
                            8'h6B: begin
                                dummy_nxt = HAS_DUMMY;
                                quad_nxt  = 1'b1;
                            end
`endif
                            default: begin
                                state_nxt = IGNORE;
                                err_nxt   = 1'b1;
                            end
                        endcase
                    end
                end
                ADDR:  if (sck_rise && cnt == 8'd23) state_nxt = use_dummy ? DUMMY : DATA;
                DUMMY: if (sck_rise && cnt == DUMMY_LAST) state_nxt = DATA;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            sck_s      <= 2'b00;
            cs_s       <= 2'b00;
            dq_s0      <= 4'h0;
            dq_s1      <= 4'h0;
            sck_d      <= 1'b0;
            cs_d       <= 1'b0;
            cs_armed   <= 1'b0;
            shreg      <= '0;
            cnt        <= 8'd0;
            use_dummy  <= 1'b0;
            rd_pend    <= 1'b0;
            pre_vld    <= 1'b0;
            drive      <= 1'b0;
            sampled    <= 1'b0;
            pre_buf    <= 8'h00;
            byte_sh    <= 8'h00;
            bits_left  <= 4'd0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            cmd_err_q  <= 1'b0;
`ifdef QSPI_RESP_QUAD_EN
            quad       <= 1'b0;
`endif
        end else begin
            sck_s     <= {sck_s[0], bus.qspi_sck};
            cs_s      <= {cs_s[0], bus.qspi_cs_0};
            dq_s0     <= bus.qspi_dq_i;
            dq_s1     <= dq_s0;
            sck_d     <= sck_s[1];
            cs_d      <= cs_s[1];
            cs_armed  <= cs_armed | cs_s[1];
            busy_q    <= ~cs_s[1] & cs_armed;
            state     <= state_nxt;
            cmd_err_q <= err_nxt;
            use_dummy <= dummy_nxt;
`ifdef QSPI_RESP_QUAD_EN
            quad      <= quad_nxt;
`endif
            mem_rd_q  <= 1'b0;
            rd_pend   <= mem_rd_q;
            if (rd_pend) begin
                pre_buf <= bus.mem_rdata;
                pre_vld <= 1'b1;
            end
            if (cs_rise || state == IDLE) begin
                cnt       <= 8'd0;
                drive     <= 1'b0;
                sampled   <= 1'b0;
                pre_vld   <= 1'b0;
                bits_left <= 4'd0;
            end else begin
                cnt <= (state_nxt != state) ? 8'd0 : cnt + {7'd0, sck_rise};
                if (sck_rise && (state == CMD || state == ADDR)) shreg <= sh_nxt;
                if (state == ADDR && state_nxt != ADDR) begin
                    mem_addr_q <= sh_nxt;
                    mem_rd_q   <= 1'b1;
                end
                if (state == DATA) begin
                    // a fall only advances the output once the master has sampled it on a rise
                    if (sck_rise) sampled <= 1'b1;
                    if ((!drive && pre_vld) || byte_end) begin
                        byte_sh    <= pre_buf;
                        pre_vld    <= 1'b0;
                        drive      <= 1'b1;
                        sampled    <= 1'b0;
                        bits_left  <= quad ? 4'd2 : 4'd8;
                        mem_addr_q <= mem_addr_q + 1'b1;
                        mem_rd_q   <= 1'b1;
                    end else if (drive && sck_fall && sampled) begin
                        byte_sh   <= quad ? {byte_sh[3:0], 4'h0} : {byte_sh[6:0], 1'b0};
                        bits_left <= bits_left - 4'd1;
                        sampled   <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.busy     = busy_q;
    assign bus.cmd_err  = cmd_err_q;
`ifdef QSPI_RESP_QUAD_EN
    assign bus.qspi_dq_oe = drive ? (quad ? 4'hF : 4'h2) : 4'h0;
    assign bus.qspi_dq_o  = !drive ? 4'h0 : (quad ? byte_sh[7:4] : {2'b00, byte_sh[7], 1'b0});
`else
    assign bus.qspi_dq_oe = {2'b00, drive, 1'b0};
    assign bus.qspi_dq_o  = {2'b00, drive & byte_sh[7], 1'b0};
`endif
endmodule

// File: tb/tb_qspi_flash_responder.sv
// Bench for qspi_flash_responder: directed reads, abort/reset cases and random transactions
// against a byte-array flash model with a scoreboard queue of expected data bytes.
module tb_qspi_flash_responder;
    localparam int AW = 16;
    localparam int H  = 6;   // sck half period in system clocks
`ifdef QSPI_RESP_QUAD_EN
    localparam bit QUAD_EN = 1'b1;
`else
    localparam bit QUAD_EN = 1'b0;
`endif

    logic clock;
    logic reset;

    qspi_flash_responder_if #(.ADDR_W(AW)) bus ();

    qspi_flash_responder #(.ADDR_W(AW), .DUMMY_CYC(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] exp_q [$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         err_seen = 0;
    int         exp_err  = 0;
    bit         data_phase = 1'b0;
    bit         exp_quad   = 1'b0;
    logic [7:0] acc;
    int         acc_n = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];

    always @(negedge clock) if (bus.cmd_err === 1'b1) err_seen++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: the master samples on sck rise; data bytes are reassembled and scored.
    always @(posedge bus.qspi_sck) begin
        if (bus.qspi_cs_0 === 1'b0) begin
            check("oe_pattern", {28'd0, bus.qspi_dq_oe},
                  !data_phase ? 32'h0 : (exp_quad ? 32'hF : 32'h2));
            check("dq_o_masked", {28'd0, bus.qspi_dq_o & ~bus.qspi_dq_oe}, 32'h0);
            if (data_phase) begin
                if (exp_quad) begin
                    acc   = {acc[3:0], bus.qspi_dq_o};
                    acc_n += 4;
                end else begin
                    acc   = {acc[6:0], bus.qspi_dq_o[1]};
                    acc_n += 1;
                end
                if (acc_n == 8) begin
                    acc_n = 0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL sb_unexpected: got byte 0x%0h, expected no byte", acc);
                    end else begin
                        check("data_byte", {24'd0, acc}, {24'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    always @(posedge bus.qspi_cs_0) acc_n = 0;

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic sck_pulse(input logic d0);
        bus.qspi_dq_i = {3'b000, d0};
        wait_clk(H);
        bus.qspi_sck = 1'b1;
        wait_clk(H);
        bus.qspi_sck = 1'b0;
    endtask

    // abort_bits >= 0: raise cs (or apply reset) after that many data-phase sck rises
    task automatic run_txn(input logic [7:0] op, input logic [23:0] addr, input int nbytes,
                           input int abort_bits, input bit do_reset);
        bit ok, q;
        int dum, slots, rises;
        logic [AW-1:0] a;
        ok    = (op == 8'h03) || (op == 8'h0B) || (QUAD_EN && op == 8'h6B);
        q     = ok && (op == 8'h6B);
        dum   = (ok && op != 8'h03) ? 8 : 0;
        slots = q ? 2 : 8;
        exp_quad = q;
        bus.qspi_cs_0 = 1'b0;
        wait_clk(H);
        for (int i = 7; i >= 0; i--) sck_pulse(op[i]);
        check("busy_on", {31'd0, bus.busy}, 32'd1);
        if (!ok) exp_err++;
        for (int i = 23; i >= 0; i--) sck_pulse(addr[i]);
        if (ok) begin
            for (int i = 0; i < dum; i++) sck_pulse(1'b0);
            rises = (abort_bits >= 0) ? abort_bits : nbytes * slots;
            for (int b = 0; b < rises / slots; b++) begin
                a = addr[AW-1:0] + AW'(b);
                exp_q.push_back(mem[a]);
            end
            data_phase = 1'b1;
            for (int i = 0; i < rises; i++) sck_pulse(1'b0);
            data_phase = 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) sck_pulse(1'b0);
        end
        wait_clk(2);
        if (do_reset) begin
            reset = 1'b1;
            wait_clk(1);
            check("rst_mid_oe",      {28'd0, bus.qspi_dq_oe}, 32'h0);
            check("rst_mid_dq_o",    {28'd0, bus.qspi_dq_o}, 32'h0);
            check("rst_mid_mem_rd",  {31'd0, bus.mem_rd}, 32'h0);
            check("rst_mid_mem_addr", {16'd0, bus.mem_addr}, 32'h0);
            check("rst_mid_busy",    {31'd0, bus.busy}, 32'h0);
            check("rst_mid_cmd_err", {31'd0, bus.cmd_err}, 32'h0);
            reset = 1'b0;
            wait_clk(2);
        end
        bus.qspi_cs_0 = 1'b1;
        wait_clk(4);
        check("oe_after_cs", {28'd0, bus.qspi_dq_oe}, 32'h0);
        check("busy_off", {31'd0, bus.busy}, 32'h0);
        wait_clk(2 * H);
        check("cmd_err_count", err_seen, exp_err);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  op;
        logic [23:0] addr;
        reset         = 1'b1;
        bus.qspi_sck  = 1'b0;
        bus.qspi_cs_0 = 1'b1;
        bus.qspi_dq_i = 4'h0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i);
        wait_clk(5);
        reset = 1'b0;
        check("rst_oe",       {28'd0, bus.qspi_dq_oe}, 32'h0);
        check("rst_dq_o",     {28'd0, bus.qspi_dq_o}, 32'h0);
        check("rst_mem_rd",   {31'd0, bus.mem_rd}, 32'h0);
        check("rst_mem_addr", {16'd0, bus.mem_addr}, 32'h0);
        check("rst_busy",     {31'd0, bus.busy}, 32'h0);
        check("rst_cmd_err",  {31'd0, bus.cmd_err}, 32'h0);
        wait_clk(2 * H);

        run_txn(8'h03, 24'h000010, 3, -1, 1'b0);   // 10 11 12
        run_txn(8'h0B, 24'h000100, 2, -1, 1'b0);   // 00 01 after dummies
        run_txn(8'h03, 24'h5AFFFE, 3, -1, 1'b0);   // FE FF 00, upper bits ignored
        run_txn(8'h9F, 24'h000000, 0, -1, 1'b0);   // unsupported
        run_txn(8'h03, 24'h000020, 1, -1, 1'b0);
        run_txn(8'h03, 24'h000030, 0, 11, 1'b0);   // abort at bit 3 of byte 2
        run_txn(8'h03, 24'h000020, 1, -1, 1'b0);
        run_txn(8'h03, 24'h000040, 0, 13, 1'b1);   // reset mid-data
        run_txn(8'h03, 24'h000020, 1, -1, 1'b0);
        run_txn(8'h6B, 24'h000040, 2, -1, 1'b0);   // quad 4,0,4,1 or cmd_err

        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
        for (int t = 0; t < 14; t++) begin
            case ($urandom_range(0, 4))
                0, 4: op = 8'h03;
                1:    op = 8'h0B;
                2:    op = 8'h6B;
                default: begin
                    op = 8'($urandom);
                    while (op == 8'h03 || op == 8'h0B || op == 8'h6B) op = 8'($urandom);
                end
            endcase
            addr = 24'($urandom);
            if ($urandom_range(0, 3) == 0)
                run_txn(op, addr, 0, $urandom_range(1, 15), 1'b0);
            else
                run_txn(op, addr, $urandom_range(1, 4), -1, 1'b0);
        end

        check("sb_drain", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
